uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/uart_tx_serializer.sv | 54 +++++
 rtl/uart_tx_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and parity types.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with a bit counter. Each shift_en edge moves the
// current LSB onto the line; done is high in the cycle after the last shift.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  serial_out,
    output logic                  done
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    // Next-state for shifter, counter and done flag.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (load) begin
            shift_d = data_in;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
            done_d  = (cnt_q == LAST_IDX);
            cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign serial_out = shift_q[0];
    assign done       = done_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, parity generation and registered
// output mux. One bit period per CLK cycle; TX_OUT and busy are flops.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);
    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic accept;
    logic load;
    logic shift_en;
    logic ser_out;
    logic ser_done;
    logic parity;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (load),
        .shift_en   (shift_en),
        .data_in    (P_DATA),
        .serial_out (ser_out),
        .done       (ser_done)
    );

    // Parity over the latched word, so input changes mid-frame have no effect.
    always_comb begin
        parity = ^data_q;
        case (par_typ_q)
            PAR_EVEN: parity = ^data_q;
            PAR_ODD:  parity = ~^data_q;
        endcase
    end

    // Next state, request capture and registered-output values.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        load      = 1'b0;
        accept    = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

        case (state_q)
            IDLE:    state_d = accept ? START : IDLE;
            START:   state_d = DATA;
            DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            load      = 1'b1;
        end

        // The bit registered onto the line is the one the next state shows.
        shift_en = (state_d == DATA);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_out;
            PARITY:  tx_d = parity;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registers; reset drives the line idle at once, aborting any frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule
